// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV64M multiply/divide unit:
// funct3 encodings, FSM states and operation-class helpers.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_rem(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: yields magnitudes at accept and
// applies the final sign correction in FIX.
module muldiv_sign_fix #(
   parameter int W = 64
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one radix-2 step per cycle, with a fast path for div-by-zero/overflow.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   state_e              r_state;
   state_e              w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [2:0]          r_op;
   logic                r_neg;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_opnd;

   logic                w_sa;
   logic                w_sb;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_b_zero;
   logic                w_ovf;
   logic                w_special;
   logic [XLEN-1:0]     w_special_res;
   logic                w_last;

   logic [XLEN:0]       w_add;
   logic [2*XLEN-1:0]   w_mul_step;
   logic [XLEN:0]       w_rem_sh;
   logic                w_ge;
   logic [XLEN-1:0]     w_diff;
   logic [2*XLEN-1:0]   w_div_step;

   logic [2*XLEN-1:0]   w_prod_fix;
   logic [XLEN-1:0]     w_div_in;
   logic [XLEN-1:0]     w_div_fix;
   logic [XLEN-1:0]     w_fix_res;

   assign w_sa = is_signed_a(op) & rs1_val[XLEN-1];
   assign w_sb = is_signed_b(op) & rs2_val[XLEN-1];

   muldiv_sign_fix #(.W(XLEN)) u_abs_a (
      .i_val (rs1_val),
      .i_neg (w_sa),
      .o_val (w_mag_a)
   );

   muldiv_sign_fix #(.W(XLEN)) u_abs_b (
      .i_val (rs2_val),
      .i_neg (w_sb),
      .o_val (w_mag_b)
   );

   assign w_b_zero  = (rs2_val == {XLEN{1'b0}});
   assign w_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (rs2_val == {XLEN{1'b1}});
   assign w_special = is_div(op) && (w_b_zero || w_ovf);
   assign w_last    = (r_cnt == CNT_W'(XLEN-1));

   // Result of the no-iteration cases (divide by zero, signed overflow)
   always_comb begin
      w_special_res = {XLEN{1'b1}};
      if (w_b_zero) begin
         if (is_rem(op)) w_special_res = rs1_val;
         else            w_special_res = {XLEN{1'b1}};
      end else begin
         if (is_rem(op)) w_special_res = {XLEN{1'b0}};
         else            w_special_res = rs1_val;
      end
   end

   // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right
   assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
   assign w_mul_step = r_acc[0] ? {w_add, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

   // Restoring divide step on {remainder, quotient}; the shifted remainder needs XLEN+1 bits
   assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
   assign w_diff     = w_rem_sh[XLEN-1:0] - r_opnd;
   assign w_div_step = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                            : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

   muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
      .i_val (r_acc),
      .i_neg (r_neg),
      .o_val (w_prod_fix)
   );

   assign w_div_in = is_rem(r_op) ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

   muldiv_sign_fix #(.W(XLEN)) u_fix_div (
      .i_val (w_div_in),
      .i_neg (r_neg),
      .o_val (w_div_fix)
   );

   // Final result selection by operation
   always_comb begin
      w_fix_res = w_div_fix;
      case (r_op)
         OP_MUL:    w_fix_res = w_prod_fix[XLEN-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
         default:   w_fix_res = w_div_fix;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // FSM next-state logic; kill overrides every transition
   always_comb begin
      w_next_state = r_state;
      if (kill) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) w_next_state = w_special ? DONE : CALC;
               else       w_next_state = IDLE;
            end
            CALC: begin
               if (w_last) w_next_state = FIX;
               else        w_next_state = CALC;
            end
            FIX:     w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // Datapath, counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= {XLEN{1'b0}};
         rd_out <= 5'd0;
         r_cnt  <= {CNT_W{1'b0}};
         r_op   <= 3'd0;
         r_neg  <= 1'b0;
         r_acc  <= {(2*XLEN){1'b0}};
         r_opnd <= {XLEN{1'b0}};
      end else if (kill) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (w_next_state == CALC) || (w_next_state == FIX);
         done <= (w_next_state == DONE);
         case (r_state)
            IDLE: begin
               if (start) begin
                  rd_out <= rd_in;
                  r_op   <= op;
                  r_neg  <= is_rem(op) ? w_sa : (w_sa ^ w_sb);
                  r_cnt  <= {CNT_W{1'b0}};
                  if (w_special) begin
                     result <= w_special_res;
                  end else if (is_div(op)) begin
                     r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                     r_opnd <= w_mag_b;
                  end else begin
                     r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                     r_opnd <= w_mag_a;
                  end
               end
            end
            CALC: begin
               r_acc <= is_div(r_op) ? w_div_step : w_mul_step;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            FIX:     result <= w_fix_res;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed vectors push expected
// result/rd/latency/busy-cycles; a negedge monitor checks each done pulse.
module tb_ex_muldiv_unit;

   localparam int XLEN = 64;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  rd;
      logic [31:0] lat;
      logic [31:0] bcyc;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            start;
   logic            kill;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   int   checks;
   int   failures;
   int   cyc;
   int   issue_cyc;
   int   busy_total;
   int   busy_base;
   exp_t sb[$];

   ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(7)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .kill    (kill),
      .op      (op),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd_in   (rd_in),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .rd_out  (rd_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Monitor: count busy cycles and score every done pulse
   always @(negedge clk) begin
      if (!reset) begin
         if (busy) busy_total++;
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'(done), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", result, e.res);
               check("rd_out", 64'(rd_out), 64'(e.rd));
               check("latency", 64'(cyc - issue_cyc), 64'(e.lat));
               check("busy_cycles", 64'(busy_total - busy_base), 64'(e.bcyc));
            end
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp_res,
                        input int exp_lat, input int exp_busy);
      exp_t e;
      @(negedge clk);
      op      = o;
      rs1_val = a;
      rs2_val = b;
      rd_in   = rd;
      start   = 1'b1;
      e.res   = exp_res;
      e.rd    = rd;
      e.lat   = 32'(exp_lat);
      e.bcyc  = 32'(exp_busy);
      issue_cyc = cyc;
      busy_base = busy_total;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      int done_cnt;
      checks = 0; failures = 0; cyc = 0; issue_cyc = 0; busy_total = 0; busy_base = 0;
      reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0;
      rs1_val = 64'd0; rs2_val = 64'd0; rd_in = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_rd_out", 64'(rd_out), 64'd0);
      reset = 1'b0;

      issue(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 66, 65);
      issue(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1,
            64'hFFFF_FFFF_FFFF_FFFE, 66, 65);
      issue(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'd0, 66, 65);
      issue(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66, 65);
      issue(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 66, 65);
      issue(3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 66, 65);
      issue(3'b111, 64'd100, 64'd7, 5'd7, 64'd2, 66, 65);
      issue(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd8, 64'h0FFF_FFFF_FFFF_FFFF, 66, 65);
      issue(3'b101, 64'd42, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      issue(3'b110, 64'd42, 64'd0, 5'd11, 64'd42, 1, 0);
      issue(3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
            64'h8000_0000_0000_0000, 1, 0);
      issue(3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0, 1, 0);

      // Kill a DIV ten cycles in: no done, result held, rd_out from the killed accept
      @(negedge clk);
      op = 3'b100; rs1_val = 64'd1000; rs2_val = 64'd3; rd_in = 5'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      @(negedge clk);
      check("kill_busy", 64'(busy), 64'd0);
      check("kill_done", 64'(done), 64'd0);
      check("kill_result_held", result, 64'd0);
      check("kill_rd_out", 64'(rd_out), 64'd9);
      done_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("kill_no_done", 64'(done_cnt), 64'd0);

      issue(3'b000, 64'd3, 64'd4, 5'd14, 64'd12, 66, 65);

      // Reset in the middle of a MUL
      @(negedge clk);
      op = 3'b000; rs1_val = 64'd5; rs2_val = 64'd6; rd_in = 5'd15; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_result", result, 64'd0);
      check("mid_rst_rd_out", 64'(rd_out), 64'd0);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("mid_rst_no_done", 64'(done_cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV64M multiply/divide unit in the EX stage. It consumes the operand, destination and funct3 fields delivered by the ID/EX pipeline register. It holds the pipeline through a busy handshake while it computes, then presents a registered 64-bit result with a one-cycle done pulse for the EX/MEM register to capture. It completes one radix-2 step per cycle and has a fast path for divide-by-zero and signed overflow.

Parameters:
XLEN, 64, operand/result width; iteration count equals XLEN.
CNT_W, 7, iteration counter width; must satisfy 2**CNT_W > XLEN.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle issue pulse from EX control; sampled only in IDLE.
kill  input  1  synchronous flush (branch mispredict); aborts any operation.
op  input  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_val  input  XLEN  operand A, from IDEX_ReadData1 after forwarding.
rs2_val  input  XLEN  operand B, from IDEX_ReadData2 after forwarding.
rd_in  input  5  destination register, from IDEX_RD.
busy  output  1  registered; high in CALC and FIX; hazard unit stalls IF/ID/EX while busy or start.
done  output  1  registered one-cycle pulse; result and rd_out are valid in that cycle.
result  output  XLEN  final value; held until the next done.
rd_out  output  5  destination latched at accept; held until the next accept.

Behaviour:
- Reset state: state=IDLE. busy, done, result, rd_out, counter and internal accumulators all 0.
- States: IDLE, CALC, FIX, DONE.
  - IDLE, start=1, special case -> DONE.
  - IDLE, start=1, otherwise -> CALC with count=0.
  - CALC -> FIX when count reaches XLEN-1 (XLEN iterations total).
  - FIX -> DONE.
  - DONE -> IDLE.
  - start is ignored outside IDLE.
- Accept edge: latch op and rd_in, and record operand signs.
  - Magnitudes are taken for signed ops: MULH (both operands), MULHSU (A only), DIV/REM (both).
  - Quotient sign = sA xor sB; remainder sign = sA; product sign = sA xor sB, where sB=0 for MULHSU.
- Multiply: shift-add on the 2*XLEN product register, one partial-product bit per cycle.
- Divide: restoring division on {remainder, quotient}, one quotient bit per cycle.
- FIX state:
  - Apply two's-complement sign correction.
  - Select the low XLEN bits of the product for MUL, the high XLEN bits for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, the remainder for REM/REMU.
  - Register the selection into result.
- Latency: done is high XLEN+2 edges after the accepting edge (66 for XLEN=64). Special cases: 1 edge.
- Special cases (no iteration):
  - B=0: DIV/DIVU -> all ones; REM/REMU -> A.
  - DIV with A=-2^(XLEN-1) and B=-1 -> A; the corresponding REM -> 0.
- busy rises on the edge after accept. The hazard unit uses start combinationally for the accept cycle itself.
- busy is low in DONE, so the stalled instruction advances in the same cycle that done is high.
- kill in any state: next state IDLE, busy=0, done=0; result and rd_out are unchanged. kill outranks start in the same cycle. A killed operation never pulses done.
- reset outranks kill. Reset mid-operation gives full reset values on the next edge.
- Back-to-back operation: a new start is accepted in the IDLE cycle that follows DONE, at the earliest.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding constants (OP_MUL ... OP_REMU);
  - the state enum (IDLE, CALC, FIX, DONE);
  - helper functions is_div(op) and is_signed_a/is_signed_b(op).
- One natural sub-module, muldiv_sign_fix: combinational magnitude/negate helper used at both accept and FIX.
- All control and the counter stay in ex_muldiv_unit.

Test Plan:
- MUL, A=7, B=-3 (0xFFFF_FFFF_FFFF_FFFD), rd_in=5 -> busy for 65 cycles; done on edge 66 with result=0xFFFF_FFFF_FFFF_FFEB and rd_out=5.
- MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> result=0.
- DIV, A=-7, B=2 -> result=-3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands -> result=-1. REMU, A=100, B=7 -> result=2.
- Divide by zero: DIVU, A=42, B=0 -> done on the next edge, result=all ones, busy never high. REM, A=42, B=0 -> result=42.
- Overflow: DIV, A=0x8000_0000_0000_0000, B=-1 -> result=0x8000_0000_0000_0000 after 1 edge. REM with the same operands -> result=0.
- kill asserted 10 cycles into a DIV -> IDLE on the next edge, no done, busy=0. A following MUL 3*4 -> result=12. Reset asserted mid-MUL -> all outputs 0 on the next edge.
